// File: rtl/axi_burst_mem_slave_if.sv
// AXI-style burst bus between an interconnect master and the burst memory.
// Carries the AW/W/B write channels and the AR/R read channels.
interface axi_burst_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// Burst memory slave: INCR writes with strobes, queued in-order reads.
// Read beats stream back-to-back across bursts from a small AR FIFO.
module axi_burst_mem_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024,
  parameter int RD_QDEPTH = 4
) (
  input logic                  sys_clk,
  input logic                  sys_rstn,
  axi_burst_mem_slave_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int HI     = LSB + IDX_W;
  localparam int QP_W   = $clog2(RD_QDEPTH);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [QP_W-1:0]  qp_t;
  typedef logic [QP_W:0]    qc_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    idx_t            idx;
    logic [7:0]      len;
    logic            err;
  } rcmd_t;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_e;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  rcmd_t             fifo [RD_QDEPTH];

  logic [ADDR_W-1:0] awa, ara;
  assign awa = bus.awaddr;
  assign ara = bus.araddr;

  wstate_e         wst_q, wst_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] wid_q, wid_d;
  idx_t            widx_q, widx_d;
  logic [7:0]      wlen_q, wlen_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic            werr_q, werr_d;
  logic            wperr_q, wperr_d;

  logic aw_hs, w_hs, b_hs, w_final, w_bad;
  assign aw_hs   = bus.awvalid && awready_q;
  assign w_hs    = bus.wvalid && wready_q;
  assign b_hs    = bvalid_q && bus.bready;
  assign w_final = wcnt_q == wlen_q;
  assign w_bad   = bus.wlast != w_final;

  always_comb begin
    wst_d     = wst_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wperr_d   = wperr_q;
    unique case (wst_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = bus.awid;
          widx_d    = awa[LSB +: IDX_W];
          wlen_d    = bus.awlen;
          wcnt_d    = 8'd0;
          werr_d    = |(awa >> HI);
          wperr_d   = 1'b0;
          wst_d     = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wcnt_d = wcnt_q + 8'd1;
          widx_d = widx_q + idx_t'(1);
          if (w_bad) wperr_d = 1'b1;
          if (w_final) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = wid_q;
            bresp_d  = (werr_q || wperr_q || w_bad)
                       ? 2'b10 : 2'b00;
            wst_d    = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wst_d     = W_IDLE;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (w_hs && !werr_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b])
          mem[widx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  logic            init_q;
  qp_t             wr_q, wr_d, rd_q, rd_d;
  qc_t             cnt_q, cnt_d;
  logic            act_q, act_d;
  rcmd_t           eng_q, eng_d;
  logic [7:0]      ecnt_q, ecnt_d;
  logic            rvalid_q, rvalid_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;

  logic  empty, full, pop, push, arready;
  logic  load, s_last;
  rcmd_t head, src, ar_cmd;
  logic [7:0] scnt;

  assign empty   = cnt_q == '0;
  assign full    = cnt_q == qc_t'(RD_QDEPTH);
  assign head    = fifo[rd_q];
  assign pop     = !act_q && !empty;
  assign arready = init_q && (!full || pop);
  assign push    = bus.arvalid && arready;
  assign ar_cmd  = '{id: bus.arid, idx: ara[LSB +: IDX_W],
                     len: bus.arlen, err: |(ara >> HI)};

  // Idle engine feeds the FIFO head straight into the output register.
  assign src    = act_q ? eng_q : head;
  assign scnt   = act_q ? ecnt_q : 8'd0;
  assign s_last = scnt == src.len;
  assign load   = (act_q || !empty)
                  && (!rvalid_q || bus.rready);

  always_comb begin
    wr_d     = wr_q + qp_t'(push);
    rd_d     = rd_q + qp_t'(pop);
    cnt_d    = cnt_q + qc_t'(push) - qc_t'(pop);
    act_d    = act_q;
    eng_d    = eng_q;
    ecnt_d   = ecnt_q;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    if (load) begin
      rvalid_d = 1'b1;
      rid_d    = src.id;
      rdata_d  = src.err ? '0 : mem[src.idx];
      rresp_d  = src.err ? 2'b10 : 2'b00;
      rlast_d  = s_last;
      act_d    = !s_last;
      eng_d    = src;
      eng_d.idx = src.idx + idx_t'(1);
      ecnt_d   = scnt + 8'd1;
    end else begin
      if (rvalid_q && bus.rready) rvalid_d = 1'b0;
      if (pop) begin
        act_d  = 1'b1;
        eng_d  = head;
        ecnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo[wr_q] <= ar_cmd;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
      wperr_q   <= 1'b0;
      init_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      act_q     <= 1'b0;
      eng_q     <= '0;
      ecnt_q    <= 8'd0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wperr_q   <= wperr_d;
      init_q    <= 1'b1;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      eng_q     <= eng_d;
      ecnt_q    <= ecnt_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Bench for axi_burst_mem_slave: word-array memory model, expected beat
// queues and a per-cycle compare process, plus directed literal checks.
module tb_axi_burst_mem_slave;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;
  localparam int MEM_WORDS = 1024;
  localparam int RD_QDEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_burst_mem_slave_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)
  ) bus ();

  axi_burst_mem_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
    .MEM_WORDS(MEM_WORDS), .RD_QDEPTH(RD_QDEPTH)
  ) dut (
    .sys_clk(clk),
    .sys_rstn(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bbeat_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] mm [MEM_WORDS];
  rbeat_t r_exp[$];
  bbeat_t b_exp[$];
  logic [31:0] obs_data[$];
  logic [3:0]  last_bid;
  logic [1:0]  last_bresp;
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  int rmode = 1;

  logic        prv_rstall, prv_bstall;
  logic [39:0] prv_r;
  logic [6:0]  prv_b;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expire(string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.rready = 1'b0;
        1: bus.rready = 1'b1;
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    prv_rstall = 1'b0;
    prv_bstall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv_rstall = 1'b0;
        prv_bstall = 1'b0;
      end else begin
        if (prv_rstall)
          chk("r_stable", {bus.rvalid, bus.rid, bus.rresp,
                           bus.rlast, bus.rdata}, prv_r);
        if (prv_bstall)
          chk("b_stable", {bus.bvalid, bus.bid, bus.bresp}, prv_b);
        prv_rstall = bus.rvalid && !bus.rready;
        prv_r = {bus.rvalid, bus.rid, bus.rresp, bus.rlast, bus.rdata};
        prv_bstall = bus.bvalid && !bus.bready;
        prv_b = {bus.bvalid, bus.bid, bus.bresp};
        if (bus.rvalid && bus.rready) begin
          if (r_exp.size() == 0) begin
            expire("r_unexpected");
          end else begin
            rbeat_t e;
            e = r_exp.pop_front();
            chk("r_beat", {bus.rid, bus.rresp, bus.rlast, bus.rdata},
                {e.id, e.resp, e.last, e.data});
            obs_data.push_back(bus.rdata);
          end
        end
        if (bus.bvalid && bus.bready) begin
          last_bid = bus.bid;
          last_bresp = bus.bresp;
          if (b_exp.size() == 0) begin
            expire("b_unexpected");
          end else begin
            bbeat_t e;
            e = b_exp.pop_front();
            chk("b_resp", {bus.bid, bus.bresp}, {e.id, e.resp});
          end
        end
      end
    end
  end

  function automatic bit out_of_range(logic [31:0] a);
    return (a / (MEM_WORDS * 4)) != 0;
  endfunction

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                             input int len, input int bad_beat,
                             input bit gaps);
    bit oor;
    int idx;
    int n;
    oor = out_of_range(addr);
    idx = int'((addr / 4) % MEM_WORDS);
    bus.awid = id;
    bus.awaddr = addr;
    bus.awlen = 8'(len);
    bus.awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.awready) break;
      if (++n > 50) begin expire("aw_wait"); break; end
    end
    tick();
    bus.awvalid = 1'b0;
    chk("wready_lat", bus.wready, 1);
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
        tick();
      end
      bus.wdata = wbuf[b];
      bus.wstrb = sbuf[b];
      bus.wlast = (b == len) != (b == bad_beat);
      bus.wvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.wready) break;
        if (++n > 50) begin expire("w_wait"); break; end
      end
      if (!oor)
        for (int k = 0; k < 4; k++)
          if (sbuf[b][k]) mm[idx][8*k +: 8] = wbuf[b][8*k +: 8];
      idx = (idx + 1) % MEM_WORDS;
      tick();
      if (b != len) chk("no_early_b", bus.bvalid, 0);
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    chk("bvalid_lat", bus.bvalid, 1);
    b_exp.push_back('{id, (oor || bad_beat >= 0) ? 2'b10 : 2'b00});
    repeat ($urandom_range(0, 2)) tick();
    bus.bready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.bvalid) break;
      if (++n > 50) begin expire("b_wait"); break; end
    end
    tick();
    bus.bready = 1'b0;
    chk("awready_after_b", bus.awready, 1);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input bit lat);
    bit oor;
    int idx;
    int n;
    oor = out_of_range(addr);
    idx = int'((addr / 4) % MEM_WORDS);
    bus.arid = id;
    bus.araddr = addr;
    bus.arlen = 8'(len);
    bus.arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.arready) break;
      if (++n > 300) begin expire("ar_wait"); break; end
    end
    for (int b = 0; b <= len; b++) begin
      r_exp.push_back('{id, oor ? 32'h0 : mm[idx],
                        oor ? 2'b10 : 2'b00, b == len});
      idx = (idx + 1) % MEM_WORDS;
    end
    tick();
    bus.arvalid = 1'b0;
    if (lat) begin
      chk("rvalid_t1", bus.rvalid, 0);
      tick();
      chk("rvalid_t2", bus.rvalid, 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (r_exp.size() != 0 || b_exp.size() != 0) begin
      tick();
      if (++n > 3000) begin expire("drain"); break; end
    end
    tick();
  endtask

  task automatic chk_obs(string name, int i, logic [31:0] exp);
    if (i < obs_data.size()) chk(name, obs_data[i], exp);
    else expire(name);
  endtask

  initial begin
    int acc;
    int gaps;
    int n;
    bit got;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {bus.awready, bus.wready, bus.bvalid, bus.bid,
                      bus.bresp, bus.arready, bus.rvalid, bus.rid,
                      bus.rdata, bus.rresp, bus.rlast}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", {bus.awready, bus.arready}, 0);
    tick();
    chk("ready_after_rst", {bus.awready, bus.arready}, 2'b11);

    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin
        wbuf[b] = 32'hC0DE0000 | 32'(k * 256 + b);
        sbuf[b] = 4'hF;
      end
      write_burst(4'(k), 32'(k * 1024), 255, -1, 1'b0);
    end

    for (int b = 0; b < 4; b++) wbuf[b] = 32'hA0 + 32'(b);
    write_burst(4'h3, 32'h10, 3, -1, 1'b0);
    chk("t1_b", {last_bid, last_bresp}, {4'h3, 2'b00});
    obs_data.delete();
    read_burst(4'h5, 32'h10, 3, 1'b1);
    drain();
    for (int b = 0; b < 4; b++) chk_obs("t1_rd", b, 32'hA0 + 32'(b));

    wbuf[0] = 32'hFFFFFFFF;
    write_burst(4'h1, 32'h20, 0, -1, 1'b0);
    wbuf[0] = 32'h11223344;
    sbuf[0] = 4'b0101;
    write_burst(4'h1, 32'h20, 0, -1, 1'b0);
    sbuf[0] = 4'hF;
    obs_data.delete();
    read_burst(4'h2, 32'h20, 0, 1'b0);
    drain();
    chk_obs("strobe_merge", 0, 32'hFF22FF44);

    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'hDEADBEEF;
    write_burst(4'h2, 32'(MEM_WORDS * 4), 1, -1, 1'b0);
    chk("oor_b", last_bresp, 2'b10);
    obs_data.delete();
    read_burst(4'h4, 32'h0, 1, 1'b0);
    read_burst(4'h6, 32'(MEM_WORDS * 4), 0, 1'b0);
    drain();
    chk_obs("oor_mem0", 0, 32'hC0DE0000);
    chk_obs("oor_mem1", 1, 32'hC0DE0001);
    chk_obs("oor_rdata", 2, 32'h0);

    for (int b = 0; b < 4; b++) wbuf[b] = 32'h5500 + 32'(b);
    write_burst(4'h7, 32'h40, 3, 1, 1'b0);
    chk("early_wlast_b", {last_bid, last_bresp}, {4'h7, 2'b10});

    for (int b = 0; b < 4; b++) wbuf[b] = 32'hB0 + 32'(b);
    write_burst(4'h8, 32'((MEM_WORDS - 2) * 4), 3, -1, 1'b0);
    chk("wrap_b", last_bresp, 2'b00);
    obs_data.delete();
    read_burst(4'h9, 32'((MEM_WORDS - 2) * 4), 3, 1'b0);
    read_burst(4'hA, 32'h0, 1, 1'b0);
    drain();
    for (int b = 0; b < 4; b++) chk_obs("wrap_rd", b, 32'hB0 + 32'(b));
    chk_obs("wrap_w0", 4, 32'hB2);
    chk_obs("wrap_w1", 5, 32'hB3);

    rmode = 0;
    tick();
    tick();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      bus.arid = 4'(k);
      bus.araddr = 32'(k * 16);
      bus.arlen = 8'd1;
      bus.arvalid = 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < 6) begin
        @(negedge clk);
        if (bus.arready) got = 1'b1;
        else n++;
      end
      if (!got) break;
      for (int b = 0; b < 2; b++)
        r_exp.push_back('{4'(k), mm[k * 4 + b], 2'b00, b == 1});
      acc++;
      tick();
    end
    chk("ar_accepted", acc, RD_QDEPTH + 1);
    chk("arready_full", bus.arready, 0);
    tick();
    bus.arvalid = 1'b0;
    repeat (3) tick();
    rmode = 1;
    tick();
    gaps = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.rvalid) gaps++;
    end
    chk("no_bubbles", gaps, 0);
    drain();

    rmode = 2;
    for (int it = 0; it < 25; it++) begin
      int nw;
      int nr;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        logic [31:0] a;
        int len;
        int bad;
        len = $urandom_range(0, 7);
        if ($urandom_range(0, 7) == 0)
          a = 32'(MEM_WORDS * 4) + ($urandom & 32'hFFC);
        else
          a = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
        for (int b = 0; b <= len; b++) begin
          wbuf[b] = $urandom;
          sbuf[b] = 4'($urandom);
        end
        bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
        write_burst(4'($urandom), a, len, bad, 1'b1);
      end
      nr = $urandom_range(1, 4);
      for (int r = 0; r < nr; r++) begin
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0)
          a = 32'(MEM_WORDS * 4) + ($urandom & 32'hFFC);
        else
          a = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
        read_burst(4'($urandom), a, $urandom_range(0, 7), 1'b0);
      end
      drain();
    end
    for (int b = 0; b < 4; b++) begin
      wbuf[b] = 32'hC0DE0010 + 32'(b);
      sbuf[b] = 4'hF;
    end
    write_burst(4'hE, 32'h40, 3, -1, 1'b0);

    rmode = 0;
    tick();
    read_burst(4'h9, 32'h40, 7, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.rvalid) break;
      if (++n > 20) begin expire("rst_rvalid"); break; end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.awready, bus.wready, bus.bvalid, bus.bid,
                      bus.bresp, bus.arready, bus.rvalid, bus.rid,
                      bus.rdata, bus.rresp, bus.rlast}, 0);
    r_exp.delete();
    repeat (2) @(negedge clk);
    rmode = 1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arready_post_rst", bus.arready, 1);
    obs_data.delete();
    read_burst(4'hB, 32'h40, 1, 1'b1);
    drain();
    chk_obs("post_rst_rd", 0, 32'hC0DE0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
